// File: rtl/io_intr_pkg.sv
// Shared types and defaults for the I/O interrupt controller.
// The vector defaults must match the CPU control unit and the assembler vector table.
package io_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [9:0]  DEF_VEC_BASE   = 10'h3C0;
  localparam int unsigned DEF_VEC_STRIDE = 4;
  localparam int unsigned ID_W           = 3;

endpackage

// File: rtl/io_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module io_prio_enc
  import io_intr_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/io_intr_ctrl.sv
// Interrupt controller: edge-detects I/O events, masks them, and runs the
// request/ack/return handshake with the CPU control unit (no nesting).
module io_intr_ctrl
  import io_intr_pkg::*;
#(
  parameter int               N_SRC      = 4,
  parameter int               PC_W       = 10,
  parameter logic [PC_W-1:0]  VEC_BASE   = PC_W'(DEF_VEC_BASE),
  parameter int unsigned      VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pending_q,
  output logic             intr_req,
  output logic [PC_W-1:0]  intr_vec,
  input  logic             intr_ack,
  input  logic             reti,
  output logic [ID_W-1:0]  active_id,
  output logic             in_service
);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] clr;
  logic             take;
  logic             win_vld;
  logic [ID_W-1:0]  win_idx;

  io_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req   (pending_q & mask_q),
    .valid (win_vld),
    .idx   (win_idx)
  );

  assign evt  = irq_in & ~irq_prev;
  assign take = (state_q == REQ) && intr_ack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = take && (active_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld)  state_d = REQ;
      REQ:     if (intr_ack) state_d = SERVICE;
      SERVICE: if (reti)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // irq_prev resets high so lines already asserted at reset release are not seen as edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      irq_prev  <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      active_id <= '0;
    end else begin
      state_q   <= state_d;
      irq_prev  <= irq_in;
      pending_q <= (pending_q & ~clr) | evt;
      if (mask_we) mask_q <= mask_wdata;
      if (state_q == IDLE && win_vld) active_id <= win_idx;
    end
  end

  // active_id is frozen outside IDLE, so the vector stays stable through REQ.
  assign intr_req   = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign intr_vec   = VEC_BASE + PC_W'(32'(active_id) * VEC_STRIDE);

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the controller's rules.
module tb_io_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask_q;
  logic [3:0] pending_q;
  logic       intr_req;
  logic [9:0] intr_vec;
  logic       intr_ack;
  logic       reti;
  logic [2:0] active_id;
  logic       in_service;

  always #5 clk = ~clk;

  io_intr_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .intr_req   (intr_req),
    .intr_vec   (intr_vec),
    .intr_ack   (intr_ack),
    .reti       (reti),
    .active_id  (active_id),
    .in_service (in_service)
  );

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] pend;
    logic       req;
    logic [9:0] vec;
    logic [2:0] id;
    logic       svc;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle_no   = 0;

  // Reference model: mode 0 = waiting, 1 = requesting, 2 = handler running.
  int         m_mode;
  logic [3:0] m_prev, m_pend, m_mask;
  int         m_id;

  function automatic obs_t model_obs();
    obs_t o;
    o.mask = m_mask;
    o.pend = m_pend;
    o.req  = (m_mode == 1);
    o.vec  = 10'(32'h3C0 + m_id * 4);
    o.id   = 3'(m_id);
    o.svc  = (m_mode == 2);
    return o;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] irq, input logic mwe,
                            input logic [3:0] mwd, input logic ack, input logic rt);
    logic [3:0] evt, cand, next_pend;
    if (!r) begin
      m_mode = 0; m_prev = 4'hF; m_pend = 4'h0; m_mask = 4'h0; m_id = 0;
      return;
    end
    evt       = irq & ~m_prev;
    m_prev    = irq;
    next_pend = m_pend;
    if (m_mode == 1 && ack) next_pend[m_id] = 1'b0;
    next_pend = next_pend | evt;
    cand      = m_pend & m_mask;
    if (m_mode == 0) begin
      if (cand != 0) begin
        for (int i = 3; i >= 0; i--) if (cand[i]) m_id = i;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (ack) m_mode = 2;
    end else begin
      if (rt) m_mode = 0;
    end
    if (mwe) m_mask = mwd;
    m_pend = next_pend;
  endtask

  // One clock: drive at negedge, push expectation, return shortly after the edge.
  task automatic cyc(input logic r, input logic [3:0] irq, input logic mwe = 1'b0,
                     input logic [3:0] mwd = 4'h0, input logic ack = 1'b0,
                     input logic rt = 1'b0);
    @(negedge clk);
    reset = r; irq_in = irq; mask_we = mwe; mask_wdata = mwd; intr_ack = ack; reti = rt;
    model_step(r, irq, mwe, mwd, ack, rt);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic spot(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    cycle_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{mask_q, pending_q, intr_req, intr_vec, active_id, in_service};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL scoreboard cyc %0d: got mask=%h pend=%h req=%b vec=%h id=%0d svc=%b, expected mask=%h pend=%h req=%b vec=%h id=%0d svc=%b",
                 cycle_no, a.mask, a.pend, a.req, a.vec, a.id, a.svc,
                 e.mask, e.pend, e.req, e.vec, e.id, e.svc);
      end
    end
  end

  initial begin
    reset = 1'b0; irq_in = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0; intr_ack = 1'b0; reti = 1'b0;

    // Reset with src 1 held high: no event on release.
    repeat (3) cyc(1'b0, 4'b0010, 1'b1, 4'hF);
    spot("reset_mask", int'(mask_q), 0);
    spot("reset_vec", int'(intr_vec), 'h3C0);
    cyc(1'b1, 4'b0010, 1'b1, 4'hF);
    repeat (10) cyc(1'b1, 4'b0010);
    spot("held_line_pending", int'(pending_q), 0);
    spot("held_line_req", int'(intr_req), 0);

    // Single source 2.
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0100);
    spot("src2_pending", int'(pending_q), 'b0100);
    spot("src2_req_early", int'(intr_req), 0);
    cyc(1'b1, 4'b0000);
    spot("src2_req", int'(intr_req), 1);
    spot("src2_vec", int'(intr_vec), 'h3C8);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    spot("src2_ack_pending", int'(pending_q), 0);
    spot("src2_in_service", int'(in_service), 1);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    spot("src2_reti", int'(in_service), 0);

    // Simultaneous sources 3 and 1.
    cyc(1'b1, 4'b1010);
    cyc(1'b1, 4'b0000);
    spot("dual_id", int'(active_id), 1);
    spot("dual_vec1", int'(intr_vec), 'h3C4);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'b0000);
    spot("dual_vec3", int'(intr_vec), 'h3CC);
    spot("dual_req3", int'(intr_req), 1);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

    // Masked source 0 latches but waits for the mask.
    cyc(1'b1, 4'b0000, 1'b1, 4'b1110);
    cyc(1'b1, 4'b0001);
    cyc(1'b1, 4'b0000);
    spot("masked_pending", int'(pending_q), 'b0001);
    spot("masked_no_req", int'(intr_req), 0);
    cyc(1'b1, 4'b0000, 1'b1, 4'hF);
    cyc(1'b1, 4'b0000);
    spot("unmasked_vec", int'(intr_vec), 'h3C0);
    spot("unmasked_req", int'(intr_req), 1);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

    // Stray strobes and events during service.
    cyc(1'b1, 4'b0100);
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    spot("stray_reti_req", int'(intr_req), 1);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0001);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
    spot("svc_no_req", int'(intr_req), 0);
    spot("svc_pending", int'(pending_q), 'b0001);
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
    spot("after_reti_idle", int'(intr_req), 0);
    cyc(1'b1, 4'b0000);
    spot("after_reti_req", int'(intr_req), 1);
    spot("after_reti_vec", int'(intr_vec), 'h3C0);

    // Reset while requesting.
    cyc(1'b0, 4'b0000);
    spot("rst_req", int'(intr_req), 0);
    spot("rst_mask", int'(mask_q), 0);
    spot("rst_pending", int'(pending_q), 0);
    cyc(1'b1, 4'b0000, 1'b1, 4'hF);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic       r, mwe, ack, rt;
      logic [3:0] irq, mwd;
      r   = ($urandom_range(0, 199) != 0);
      irq = 4'($urandom_range(0, 15));
      mwe = ($urandom_range(0, 9) == 0);
      mwd = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      cyc(r, irq, mwe, mwd, ack, rt);
    end

    repeat (3) @(posedge clk);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
